// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StDrop
   } ifq_state_e;

   localparam int unsigned WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module ifq_fifo
   import ifq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  ifq_entry_t             wdata_i,
   input  logic                   pop_i,
   output ifq_entry_t             rdata_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   ifq_entry_t      mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q;
   logic [PtrW-1:0] rptr_q;
   logic [CntW-1:0] count_q;
   logic            empty;
   logic            pop_eff;

   assign empty   = (count_q == '0);
   assign pop_eff = pop_i & ~empty;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            wptr_q <= wptr_q + PtrW'(1);
         end
         if (pop_eff) begin
            rptr_q <= rptr_q + PtrW'(1);
         end
         count_q <= count_q + CntW'(push_i) - CntW'(pop_eff);
      end
   end

   // Storage needs no reset; the count gates what is visible.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = empty ? '0 : mem_q[rptr_q];
   assign count_o = count_q;

   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
      !(push_i && !flush_i && (count_q == CntW'(DEPTH)) && !pop_eff));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues word fetches over req/ack, buffers {pc, instr} and flushes on redirect.
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   redirect_i,
   input  logic [31:0]            redirect_pc_i,
   output logic                   mem_req_o,
   output logic [31:0]            mem_addr_o,
   input  logic                   mem_ack_i,
   input  logic [31:0]            mem_data_i,
   output logic                   instr_valid_o,
   output logic [31:0]            instr_o,
   output logic [31:0]            instr_pc_o,
   input  logic                   instr_ready_i,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned    CntW     = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

   ifq_state_e      state_q, state_d;
   logic [31:0]     fpc_q, fpc_d;
   logic            mem_req_q;
   logic [31:0]     mem_addr_q;
   logic            push, pop;
   logic [CntW-1:0] count, count_nxt;
   ifq_entry_t      wdata, head;

   // Redirect overrides push and pop; the FIFO flush handles the rest.
   assign push      = (state_q == StReq) & mem_ack_i & ~redirect_i;
   assign pop       = instr_valid_o & instr_ready_i & ~redirect_i;
   assign count_nxt = count + CntW'(push) - CntW'(pop);

   always_comb begin
      fpc_d = fpc_q;
      if (redirect_i) begin
         fpc_d = redirect_pc_i & ~32'h3;
      end else if (push) begin
         fpc_d = fpc_q + 32'(WORD_BYTES);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (redirect_i || (count < DepthCnt)) state_d = StReq;
         end
         StReq: begin
            if (redirect_i) begin
               state_d = mem_ack_i ? StReq : StDrop;
            end else begin
               state_d = (count_nxt < DepthCnt) ? StReq : StIdle;
            end
         end
         StDrop: begin
            if (redirect_i) begin
               state_d = StDrop;
            end else if (mem_ack_i) begin
               state_d = (count_nxt < DepthCnt) ? StReq : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // While dropping, the abandoned address is held until its ack arrives.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= StIdle;
         fpc_q      <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         mem_req_q  <= (state_d != StIdle);
         mem_addr_q <= (state_d == StDrop) ? mem_addr_q : fpc_d;
      end
   end

   assign wdata.pc    = fpc_q;
   assign wdata.instr = mem_data_i;

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (push),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign instr_valid_o = (count != '0);
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;
   assign count_o       = count;

endmodule
